// File: rtl/microwave_control_pkg.sv
// Shared types and defaults for the microwave cooking controller.
// State encoding is visible on state_code, so it is fixed here.
package microwave_pkg;

   localparam int unsigned STATE_W = 2;
   localparam int unsigned CNT_W   = 8;

   localparam int unsigned DEF_DEBOUNCE_CYCLES = 4;
   localparam int unsigned DEF_BEEP_CYCLES     = 8;

   typedef enum logic [STATE_W-1:0] {
      ST_IDLE  = 2'd0,
      ST_COOK  = 2'd1,
      ST_PAUSE = 2'd2,
      ST_DONE  = 2'd3
   } state_e;

   function automatic logic [CNT_W-1:0] cnt_max(
      input int unsigned n
   );
      return CNT_W'(n);
   endfunction

endpackage

// File: rtl/microwave_control_if.sv
// Panel/timer signal bundle for the microwave controller.
// slave = controller side, master = panel, door and timer side.
interface microwave_control_if;
   import microwave_pkg::*;

   logic               startn;
   logic               stopn;
   logic               door_closed;
   logic               timer_zero;
   logic               mag_on;
   logic               timer_clearn;
   logic               beep;
   logic [STATE_W-1:0] state_code;

   modport slave (
      input  startn,
      input  stopn,
      input  door_closed,
      input  timer_zero,
      output mag_on,
      output timer_clearn,
      output beep,
      output state_code
   );

   modport master (
      output startn,
      output stopn,
      output door_closed,
      output timer_zero,
      input  mag_on,
      input  timer_clearn,
      input  beep,
      input  state_code
   );

endinterface

// File: rtl/microwave_control_button_debounce.sv
// Active-low button: 2-flop synchronizer, saturating low-level
// counter and a single press pulse per accepted press.
module button_debounce
   import microwave_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
   input  logic clock,
   input  logic resetn,
   input  logic btn_n,
   output logic press
);

   localparam logic [CNT_W-1:0] LIMIT = cnt_max(DEBOUNCE_CYCLES);

   logic             sync1_q;
   logic             sync2_q;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;
   logic             press_q;
   logic             press_d;

   always_comb begin
      cnt_d   = cnt_q;
      press_d = 1'b0;
      if (sync2_q) begin
         cnt_d = '0;
      end else if (cnt_q != LIMIT) begin
         cnt_d   = cnt_q + CNT_W'(1);
         // Saturation guarantees one pulse per press.
         press_d = (cnt_d == LIMIT);
      end
   end

   always_ff @(posedge clock) begin
      if (!resetn) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
         cnt_q   <= '0;
         press_q <= 1'b0;
      end else begin
         sync1_q <= btn_n;
         sync2_q <= sync1_q;
         cnt_q   <= cnt_d;
         press_q <= press_d;
      end
   end

   assign press = press_q;

endmodule

// File: rtl/microwave_control.sv
// Cooking-control FSM: debounced START/STOP, door tracking,
// magnetron enable, timer clear pulse and end-of-cooking beep.
module microwave_control
   import microwave_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int unsigned BEEP_CYCLES     = DEF_BEEP_CYCLES
) (
   input  logic                clock,
   input  logic                resetn,
   microwave_control_if.slave  io
);

   localparam logic [CNT_W-1:0] BEEP_LAST = cnt_max(BEEP_CYCLES - 1);

   logic             start_evt;
   logic             stop_evt;
   logic             door1_q;
   logic             door_s_q;
   logic             start_ok;

   state_e           state_q;
   state_e           state_d;
   logic             clearn_q;
   logic             clearn_d;
   logic             beep_q;
   logic             beep_d;
   logic [CNT_W-1:0] beep_cnt_q;
   logic [CNT_W-1:0] beep_cnt_d;

   button_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
   ) u_start (
      .clock  (clock),
      .resetn (resetn),
      .btn_n  (io.startn),
      .press  (start_evt)
   );

   button_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
   ) u_stop (
      .clock  (clock),
      .resetn (resetn),
      .btn_n  (io.stopn),
      .press  (stop_evt)
   );

   assign start_ok = start_evt & door_s_q & ~io.timer_zero;

   always_comb begin
      state_d    = state_q;
      clearn_d   = 1'b1;
      beep_cnt_d = beep_cnt_q;
      unique case (state_q)
         ST_IDLE: begin
            if (stop_evt) begin
               clearn_d = 1'b0;
            end else if (start_ok) begin
               state_d = ST_COOK;
            end
         end
         ST_COOK: begin
            if (io.timer_zero) begin
               state_d    = ST_DONE;
               beep_cnt_d = '0;
            end else if (!door_s_q || stop_evt) begin
               state_d = ST_PAUSE;
            end
         end
         ST_PAUSE: begin
            if (stop_evt) begin
               state_d  = ST_IDLE;
               clearn_d = 1'b0;
            end else if (start_ok) begin
               state_d = ST_COOK;
            end
         end
         ST_DONE: begin
            // Cancel leaves the timer alone; it already reads zero.
            if (stop_evt || beep_cnt_q == BEEP_LAST) begin
               state_d = ST_IDLE;
            end else begin
               beep_cnt_d = beep_cnt_q + CNT_W'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase
      beep_d = (state_d == ST_DONE);
   end

   always_ff @(posedge clock) begin
      if (!resetn) begin
         door1_q    <= 1'b0;
         door_s_q   <= 1'b0;
         state_q    <= ST_IDLE;
         clearn_q   <= 1'b1;
         beep_q     <= 1'b0;
         beep_cnt_q <= '0;
      end else begin
         door1_q    <= io.door_closed;
         door_s_q   <= door1_q;
         state_q    <= state_d;
         clearn_q   <= clearn_d;
         beep_q     <= beep_d;
         beep_cnt_q <= beep_cnt_d;
      end
   end

   assign io.mag_on       = (state_q == ST_COOK) & door_s_q;
   assign io.timer_clearn = clearn_q;
   assign io.beep         = beep_q;
   assign io.state_code   = state_q;

endmodule

// File: tb/tb_microwave_control.sv
// Scoreboard bench for microwave_control with a small countdown
// timer model wired to mag_on / timer_clearn.
module tb_microwave_control;
   import microwave_pkg::*;

   localparam int unsigned DB = 4;
   localparam int unsigned BP = 8;

   localparam logic [4:0] M4 = 5'b11110;
   localparam logic [4:0] M5 = 5'b11111;

   typedef struct packed {
      int          cyc;
      logic [63:0] name;
      logic [1:0]  st;
      logic        mag;
      logic        clr;
      logic        bp;
      logic        tz;
      logic [4:0]  mask;
   } exp_t;

   logic clock = 1'b0;
   logic resetn;
   always #5 clock = ~clock;

   microwave_control_if mw();

   microwave_control #(
      .DEBOUNCE_CYCLES (DB),
      .BEEP_CYCLES     (BP)
   ) dut (
      .clock  (clock),
      .resetn (resetn),
      .io     (mw.slave)
   );

   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   logic [15:0] tmr_cnt = '0;
   logic [15:0] tmr_val;
   logic        tmr_load;
   logic        use_timer;
   logic        tz_force;

   always @(posedge clock) begin
      if (!resetn || !mw.timer_clearn)
         tmr_cnt <= '0;
      else if (tmr_load)
         tmr_cnt <= tmr_val;
      else if (mw.mag_on && tmr_cnt != 0)
         tmr_cnt <= tmr_cnt - 16'd1;
   end

   assign mw.timer_zero = use_timer ? (tmr_cnt == 16'd0) : tz_force;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   task automatic tick(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   task automatic expect_at(
      input int          k,
      input logic [63:0] nm,
      input logic [1:0]  st,
      input logic        mg,
      input logic        cl,
      input logic        bz,
      input logic        zv,
      input logic [4:0]  mk
   );
      exp_t e;
      e.cyc  = cyc + k;
      e.name = nm;
      e.st   = st;
      e.mag  = mg;
      e.clr  = cl;
      e.bp   = bz;
      e.tz   = zv;
      e.mask = mk;
      sb.push_back(e);
   endtask

   task automatic press(input bit is_stop, input int hold);
      if (is_stop) mw.stopn = 1'b0;
      else         mw.startn = 1'b0;
      tick(hold);
      mw.stopn  = 1'b1;
      mw.startn = 1'b1;
   endtask

   always @(negedge clock) begin
      int   i;
      exp_t e;
      logic ok;
      i = 0;
      while (i < sb.size()) begin
         e = sb[i];
         if (e.cyc < cyc) begin
            checks++;
            errors++;
            $display("FAIL %0s: cycle %0d expectation never sampled",
                     e.name, e.cyc);
            sb.delete(i);
         end else if (e.cyc == cyc) begin
            ok = 1'b1;
            if (e.mask[4] && mw.state_code !== e.st)   ok = 1'b0;
            if (e.mask[3] && mw.mag_on !== e.mag)      ok = 1'b0;
            if (e.mask[2] && mw.timer_clearn !== e.clr) ok = 1'b0;
            if (e.mask[1] && mw.beep !== e.bp)         ok = 1'b0;
            if (e.mask[0] && mw.timer_zero !== e.tz)   ok = 1'b0;
            checks++;
            if (!ok) begin
               errors++;
               $display({"FAIL %0s cyc %0d: got st=%0d mag=%b clr=%b ",
                         "beep=%b zero=%b, want st=%0d mag=%b clr=%b ",
                         "beep=%b zero=%b (mask %b)"},
                        e.name, cyc, mw.state_code, mw.mag_on,
                        mw.timer_clearn, mw.beep, mw.timer_zero,
                        e.st, e.mag, e.clr, e.bp, e.tz, e.mask);
            end
            sb.delete(i);
         end else begin
            i++;
         end
      end
   end

   initial begin
      resetn         = 1'b0;
      mw.startn      = 1'b1;
      mw.stopn       = 1'b1;
      mw.door_closed = 1'b0;
      tz_force       = 1'b0;
      use_timer      = 1'b0;
      tmr_load       = 1'b0;
      tmr_val        = '0;

      tick(1);
      expect_at(0, "reset", ST_IDLE, 0, 1, 0, 0, M4);
      tick(1);
      expect_at(0, "reset", ST_IDLE, 0, 1, 0, 0, M4);
      resetn         = 1'b1;
      mw.door_closed = 1'b1;
      tick(3);

      for (int k = 0; k < 28; k++)
         expect_at(k, "bounce", ST_IDLE, 0, 1, 0, 0, M4);
      for (int j = 0; j < 5; j++) begin
         mw.startn = 1'b0;
         tick(2);
         mw.startn = 1'b1;
         tick(2);
      end
      tick(8);

      expect_at(6, "st_wait", ST_IDLE, 0, 1, 0, 0, M4);
      expect_at(7, "st_cook", ST_COOK, 1, 1, 0, 0, M4);
      press(0, 10);
      tick(4);

      mw.door_closed = 1'b0;
      expect_at(1, "dr_cook", ST_COOK, 1, 1, 0, 0, M4);
      expect_at(2, "dr_magof", ST_COOK, 0, 1, 0, 0, M4);
      expect_at(3, "dr_pause", ST_PAUSE, 0, 1, 0, 0, M4);
      tick(4);

      for (int k = 6; k <= 8; k++)
         expect_at(k, "pd_start", ST_PAUSE, 0, 1, 0, 0, M4);
      press(0, 8);
      tick(4);

      mw.door_closed = 1'b1;
      tick(3);
      expect_at(0, "rs_pause", ST_PAUSE, 0, 1, 0, 0, M4);
      expect_at(6, "rs_wait", ST_PAUSE, 0, 1, 0, 0, M4);
      expect_at(7, "rs_cook", ST_COOK, 1, 1, 0, 0, M4);
      press(0, 8);
      tick(4);

      expect_at(6, "stop1", ST_COOK, 1, 1, 0, 0, M4);
      for (int k = 7; k <= 9; k++)
         expect_at(k, "stop1", ST_PAUSE, 0, 1, 0, 0, M4);
      press(1, 8);
      tick(4);

      expect_at(6, "stop2", ST_PAUSE, 0, 1, 0, 0, M4);
      expect_at(7, "stop2", ST_IDLE, 0, 0, 0, 0, M4);
      expect_at(8, "stop2", ST_IDLE, 0, 1, 0, 0, M4);
      expect_at(9, "stop2", ST_IDLE, 0, 1, 0, 0, M4);
      press(1, 8);
      tick(4);

      expect_at(6, "stopidle", ST_IDLE, 0, 1, 0, 0, M4);
      expect_at(7, "stopidle", ST_IDLE, 0, 0, 0, 0, M4);
      expect_at(8, "stopidle", ST_IDLE, 0, 1, 0, 0, M4);
      expect_at(9, "stopidle", ST_IDLE, 0, 1, 0, 0, M4);
      press(1, 8);
      tick(4);

      expect_at(7, "dn_cook", ST_COOK, 1, 1, 0, 0, M4);
      press(0, 8);
      tick(2);
      mw.door_closed = 1'b0;
      tick(2);
      tz_force = 1'b1;
      expect_at(0, "dn_cook", ST_COOK, 0, 1, 0, 0, M4);
      for (int k = 1; k <= 8; k++)
         expect_at(k, "dn_beep", ST_DONE, 0, 1, 1, 0, M4);
      expect_at(9, "dn_idle", ST_IDLE, 0, 1, 0, 0, M4);
      expect_at(10, "dn_idle", ST_IDLE, 0, 1, 0, 0, M4);
      tick(12);

      mw.door_closed = 1'b1;
      tick(3);
      expect_at(7, "dn_start", ST_IDLE, 0, 1, 0, 0, M4);
      expect_at(8, "dn_start", ST_IDLE, 0, 1, 0, 0, M4);
      press(0, 8);
      tick(4);

      tz_force  = 1'b0;
      use_timer = 1'b1;
      tmr_val   = 16'd5;
      tmr_load  = 1'b1;
      tick(1);
      tmr_load  = 1'b0;
      expect_at(6, "it_wait", ST_IDLE, 0, 1, 0, 0, M5);
      for (int k = 7; k <= 11; k++)
         expect_at(k, "it_cook", ST_COOK, 1, 1, 0, 0, M5);
      expect_at(12, "it_zero", ST_COOK, 1, 1, 0, 1, M5);
      expect_at(13, "it_done", ST_DONE, 0, 1, 1, 1, M5);
      expect_at(21, "it_idle", ST_IDLE, 0, 1, 0, 1, M5);
      press(0, 8);
      tick(16);

      tmr_val  = 16'd30;
      tmr_load = 1'b1;
      tick(1);
      tmr_load = 1'b0;
      expect_at(7, "mr_cook", ST_COOK, 1, 1, 0, 0, M5);
      press(0, 8);
      tick(2);
      expect_at(7, "mr_pause", ST_PAUSE, 0, 1, 0, 0, M5);
      press(1, 8);
      tick(4);
      expect_at(0, "mr_pause", ST_PAUSE, 0, 1, 0, 0, M5);
      expect_at(7, "mr_clr", ST_IDLE, 0, 0, 0, 0, M5);
      expect_at(8, "mr_zero", ST_IDLE, 0, 1, 0, 1, M5);
      press(1, 8);
      tick(4);

      use_timer = 1'b0;
      tz_force  = 1'b0;
      expect_at(7, "rm_cook", ST_COOK, 1, 1, 0, 0, M4);
      press(0, 8);
      resetn = 1'b0;
      expect_at(1, "rm_reset", ST_IDLE, 0, 1, 0, 0, M4);
      tick(1);
      resetn = 1'b1;
      expect_at(2, "rm_idle", ST_IDLE, 0, 1, 0, 0, M4);
      tick(4);

      if (sb.size() != 0) begin
         checks += sb.size();
         errors += sb.size();
         $display("FAIL leftover: %0d expectations pending, want 0",
                  sb.size());
      end
      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
